// File: rtl/vscale_regfile_sb.sv
// vscale_regfile_sb: integer register file with a pending-write scoreboard.
//
// Two combinational read ports, a primary writeback port (wen/wa/wd) and a
// long-latency writeback port (lwen/lwa/lwd) that also retires the pending
// reservation of its destination. rsv_en/rsv_wa marks a destination busy,
// flush drops every reservation. Register 0 reads as zero and is never busy.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   ra1/ra2 -> rd1/rd2      read address -> read data
//   rs1_busy/rs2_busy       addressed register awaits a long-latency result
//   wen, wa, wd             primary writeback
//   lwen, lwa, lwd          long-latency writeback, clears busy[lwa]
//   rsv_en, rsv_wa          reserve destination, sets busy[rsv_wa]
//   flush                   clear all busy bits
//   busy_count              number of busy registers
module vscale_regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wen,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            lwen,
  input  logic [AW-1:0]   lwa,
  input  logic [XLEN-1:0] lwd,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_wa,
  input  logic            flush,
  output logic [AW:0]     busy_count
);

  localparam bit Byp = (BYPASS != 0);

  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;

  // Data array is deliberately not reset. The primary port is assigned last so
  // it wins a same-address collision with the long-latency port.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (lwen && (lwa != '0)) mem[lwa] <= lwd;
      if (wen && (wa != '0))   mem[wa]  <= wd;
    end
  end

  // Reserve is applied after clear so a same-address reserve+clear stays set.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (lwen)   busy_d[lwa]    = 1'b0;
      if (rsv_en) busy_d[rsv_wa] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      count_d = count_d + (AW + 1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_count = count_q;

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0]   addr,
                                                input logic [XLEN-1:0] stored);
    logic [XLEN-1:0] val;
    if (addr == '0)                        val = '0;
    else if (Byp && wen && (wa == addr))   val = wd;
    else if (Byp && lwen && (lwa == addr)) val = lwd;
    else                                   val = stored;
    return val;
  endfunction

  always_comb begin
    rd1 = read_port(ra1, mem[ra1]);
    rd2 = read_port(ra2, mem[ra2]);
  end

  // A result arriving this cycle already satisfies the dependency when bypassed.
  always_comb begin
    rs1_busy = busy_q[ra1] && !(Byp && lwen && (lwa == ra1));
    rs2_busy = busy_q[ra2] && !(Byp && lwen && (lwa == ra2));
  end

endmodule

// File: tb/tb_vscale_regfile_sb.sv
module tb_vscale_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [AW-1:0]   ra1 = '0, ra2 = '0, wa = '0, lwa = '0, rsv_wa = '0;
  logic [XLEN-1:0] wd = '0, lwd = '0;
  logic            wen = 1'b0, lwen = 1'b0, rsv_en = 1'b0, flush = 1'b0;

  logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic            rs1_busy_b, rs2_busy_b, rs1_busy_n, rs2_busy_n;
  logic [AW:0]     cnt_b, cnt_n;

  always #5 clk = ~clk;

  vscale_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b), .wen(wen), .wa(wa), .wd(wd),
    .lwen(lwen), .lwa(lwa), .lwd(lwd), .rsv_en(rsv_en), .rsv_wa(rsv_wa),
    .flush(flush), .busy_count(cnt_b)
  );

  vscale_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_n (
    .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .rs1_busy(rs1_busy_n), .rs2_busy(rs2_busy_n), .wen(wen), .wa(wa), .wd(wd),
    .lwen(lwen), .lwa(lwa), .lwd(lwd), .rsv_en(rsv_en), .rsv_wa(rsv_wa),
    .flush(flush), .busy_count(cnt_n)
  );

  // Reference model: architectural contents, written-since-reset flags, busy set.
  logic [XLEN-1:0]  m_data [NREGS];
  bit   [NREGS-1:0] m_valid = '0;
  bit   [NREGS-1:0] m_busy  = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected read for one port; returns 0 in ok when the value is undefined.
  task automatic exp_rd(input logic [AW-1:0] a, input bit byp,
                        output logic [XLEN-1:0] v, output bit ok);
    ok = 1'b1;
    v  = '0;
    if (a == 0)                        v = '0;
    else if (byp && wen && wa == a)    v = wd;
    else if (byp && lwen && lwa == a)  v = lwd;
    else if (m_valid[a])               v = m_data[a];
    else                               ok = 1'b0;
  endtask

  function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && lwen && lwa == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic compare_outputs();
    logic [XLEN-1:0] v;
    bit ok;
    exp_rd(ra1, 1'b1, v, ok); if (ok) check_eq("rd1_byp", rd1_b, v);
    exp_rd(ra2, 1'b1, v, ok); if (ok) check_eq("rd2_byp", rd2_b, v);
    exp_rd(ra1, 1'b0, v, ok); if (ok) check_eq("rd1_nobyp", rd1_n, v);
    exp_rd(ra2, 1'b0, v, ok); if (ok) check_eq("rd2_nobyp", rd2_n, v);
    check_eq("rs1_busy_byp", rs1_busy_b, exp_busy(ra1, 1'b1));
    check_eq("rs2_busy_byp", rs2_busy_b, exp_busy(ra2, 1'b1));
    check_eq("rs1_busy_nobyp", rs1_busy_n, exp_busy(ra1, 1'b0));
    check_eq("rs2_busy_nobyp", rs2_busy_n, exp_busy(ra2, 1'b0));
    check_eq("busy_count_byp", cnt_b, $countones(m_busy));
    check_eq("busy_count_nobyp", cnt_n, $countones(m_busy));
  endtask

  task automatic model_edge();
    if (!reset_n) return;
    if (lwen && lwa != 0) begin m_data[lwa] = lwd; m_valid[lwa] = 1'b1; end
    if (wen && wa != 0)   begin m_data[wa]  = wd;  m_valid[wa]  = 1'b1; end
    if (flush) m_busy = '0;
    else begin
      if (lwen)   m_busy[lwa]    = 1'b0;
      if (rsv_en) m_busy[rsv_wa] = 1'b1;
    end
    m_busy[0] = 1'b0;
  endtask

  // Inputs are set by the caller; outputs sampled mid-cycle, model steps on the edge.
  task automatic cycle();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wen = 0; lwen = 0; rsv_en = 0; flush = 0;
  endtask

  initial begin
    // Reset from time zero.
    idle();
    cycle();
    check_eq("reset_count", cnt_b, 0);
    cycle();
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // x0 handling.
    wen = 1; wa = 0; wd = 32'hDEADBEEF; rsv_en = 1; rsv_wa = 0; ra1 = 0;
    cycle();
    idle();
    cycle();
    check_eq("x0_rd1", rd1_b, 0);
    check_eq("x0_busy", rs1_busy_b, 0);
    check_eq("x0_count", cnt_b, 0);

    // Write/read visibility: preload x3 with a known old value.
    wen = 1; wa = 3; wd = 32'h5555; cycle();
    wen = 1; wa = 3; wd = 32'h1234; ra1 = 3;
    #1;
    check_eq("byp_same_cycle", rd1_b, 32'h1234);
    check_eq("nobyp_old_value", rd1_n, 32'h5555);
    cycle();
    idle();
    #1;
    check_eq("byp_after_edge", rd1_b, 32'h1234);
    check_eq("nobyp_after_edge", rd1_n, 32'h1234);

    // Dual-write collision.
    wen = 1; wa = 7; wd = 32'hA; lwen = 1; lwa = 7; lwd = 32'hB; ra2 = 7;
    #1;
    check_eq("collide_byp_rd2", rd2_b, 32'hA);
    cycle();
    idle();
    #1;
    check_eq("collide_stored_b", rd2_b, 32'hA);
    check_eq("collide_stored_n", rd2_n, 32'hA);

    // Scoreboard lifecycle.
    rsv_en = 1; rsv_wa = 4; cycle();
    rsv_en = 1; rsv_wa = 4; cycle();
    idle(); #1;
    check_eq("rsv_twice_count", cnt_b, 1);
    rsv_en = 1; rsv_wa = 4; lwen = 1; lwa = 4; lwd = 32'h44; cycle();
    idle(); ra1 = 4; #1;
    check_eq("rsv_wins_busy", rs1_busy_b, 1);
    lwen = 1; lwa = 4; lwd = 32'h45; #1;
    check_eq("clear_byp_busy", rs1_busy_b, 0);
    check_eq("clear_nobyp_busy", rs1_busy_n, 1);
    cycle();
    idle(); #1;
    check_eq("clear_count", cnt_b, 0);
    // Clear of an idle register must not underflow.
    lwen = 1; lwa = 9; lwd = 32'h9; cycle();
    idle(); #1;
    check_eq("clear_idle_count", cnt_b, 0);

    // Flush priority.
    for (int r = 1; r < NREGS; r++) begin
      rsv_en = 1; rsv_wa = AW'(r); cycle();
    end
    idle(); #1;
    check_eq("full_count", cnt_b, 31);
    flush = 1; rsv_en = 1; rsv_wa = 2; lwen = 1; lwa = 3; lwd = 32'hCAFE0003;
    cycle();
    idle(); ra1 = 2; ra2 = 3; #1;
    check_eq("flush_count", cnt_b, 0);
    check_eq("flush_busy2", rs1_busy_b, 0);
    check_eq("flush_data3", rd2_n, 32'hCAFE0003);

    // Reset mid-operation, between clock edges.
    rsv_en = 1; rsv_wa = 5; cycle();
    rsv_en = 1; rsv_wa = 9; cycle();
    idle(); ra1 = 5;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_count", cnt_b, 0);
    check_eq("async_rst_busy", rs1_busy_b, 0);
    m_busy  = '0;
    m_valid = '0;
    // Writes and reserves during reset must be ignored.
    wen = 1; wa = 6; wd = 32'h66; rsv_en = 1; rsv_wa = 6;
    cycle();
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    ra1 = 6;
    check_eq("rst_rsv_ignored", cnt_b, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      ra1    = AW'($urandom);
      ra2    = AW'($urandom);
      wen    = ($urandom_range(0, 1) == 1);
      wa     = AW'($urandom);
      wd     = $urandom;
      lwen   = ($urandom_range(0, 2) == 0);
      lwa    = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      lwd    = $urandom;
      rsv_en = ($urandom_range(0, 4) < 2);
      rsv_wa = ($urandom_range(0, 3) == 0) ? lwa : AW'($urandom);
      flush  = ($urandom_range(0, 39) == 0);
      if (i < 40) ra1 = lwa;
      cycle();
    end
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vscale_regfile_sb.md
# vscale_regfile_sb

Parametrised integer register file with a per-register pending-write scoreboard, serving the decode/writeback stages of the vscale pipeline. It provides two combinational read ports, a primary writeback port, and a second writeback port for long-latency results such as loads and mul/div. A reserve/clear scoreboard reports which source registers still wait on an outstanding result. Register 0 is hardwired to zero and is never busy.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, register count; power of two, at least 2; AW = log2(NREGS)
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = writes visible next cycle only

- clk  in  1  clock, all state updates on posedge
- reset_n  in  1  one clock; reset is asynchronous and active-low
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  XLEN  read data
- rs1_busy, rs2_busy  out  1  addressed register has a pending long-latency write
- wen, wa, wd  in  1/AW/XLEN  primary writeback port
- lwen, lwa, lwd  in  1/AW/XLEN  long-latency writeback port; also clears busy[lwa]
- rsv_en, rsv_wa  in  1/AW  reserve destination; sets busy[rsv_wa]
- flush  in  1  clear every busy bit (pipeline kill)
- busy_count  out  AW+1  number of busy registers

## Operation
- State: data array NREGS x XLEN (not reset); busy vector NREGS bits; busy_count register.
- Address 0: reads return 0; rs*_busy is 0; writes, reserves and clears to 0 are ignored.
- Write ports: any write with address != 0 updates data[addr] at posedge. If wen and lwen hit the same address in one cycle, wd is stored.
- Reads are combinational. BYPASS=1 gives this priority: wen with wa==ra → wd; else lwen with lwa==ra → lwd; else data[ra]. BYPASS=0 always returns data[ra].
- rs*_busy is busy[ra]. With BYPASS=1 it is forced to 0 when lwen && lwa==ra in that cycle.
- Busy update per cycle, in priority order:
  - flush → all bits 0, regardless of rsv_en and lwen.
  - Otherwise rsv_en sets busy[rsv_wa] and lwen clears busy[lwa].
  - Same address in both → stays set (reserve wins).
- Only lwen clears busy; wen never touches busy.
- busy_count equals the popcount of busy after every edge. Range 0..NREGS-1.
  - Reserve of an already-busy register does not double count.
  - Clear of an idle register does not go negative.
- Data writes and busy updates are suppressed while reset_n is low.

## Timing
- Reset: busy = 0 and busy_count = 0 immediately on reset_n falling, independent of clk. rs1_busy and rs2_busy read 0 during and after reset.
- Data array contents are undefined after reset. rd1/rd2 are defined only for address 0 or for registers written since reset.
- Write latency: 1 cycle (visible from the next cycle). With BYPASS=1, also visible combinationally in the same cycle.
- Reserve latency: busy visible the cycle after rsv_en.
- Clear latency: busy drops the cycle after lwen. With BYPASS=1, rs*_busy already reads 0 in the lwen cycle.
- Reset release: the first posedge with reset_n high performs normal updates. Pending reservations are lost across reset.
- No handshakes: every request is accepted in the cycle it is presented.

## Test plan
- Reset mid-operation:
  - Stimulus: reserve x5 and x9, then assert reset_n=0 between clock edges.
  - Required: busy_count drops to 0 with no clock edge; rs1_busy(ra1=5) reads 0.
- x0 handling:
  - Stimulus: wen wa=0 wd=0xDEADBEEF; rsv_en rsv_wa=0.
  - Required: rd1(ra1=0)=0, rs1_busy=0, busy_count=0.
- Write/read with BYPASS=1:
  - Stimulus: wen wa=3 wd=0x1234 with ra1=3, same cycle.
  - Required: rd1=0x1234 in that cycle and after the edge.
  - Same stimulus with BYPASS=0: rd1 still shows the old value in that cycle, 0x1234 after the edge.
- Dual-write collision:
  - Stimulus: wen wa=7 wd=0xA, and lwen lwa=7 lwd=0xB, same cycle.
  - Required: data[7]=0xA next cycle; with BYPASS=1, rd2(ra2=7)=0xA in the collision cycle.
- Scoreboard lifecycle:
  - Reserve x4, then reserve x4 again → busy_count=1.
  - lwen lwa=4 plus rsv_en rsv_wa=4 in the same cycle → busy[4] stays 1.
  - lwen lwa=4 alone → busy_count=0; rs1_busy(ra1=4) is 0 in the lwen cycle (BYPASS=1).
- Flush priority:
  - Stimulus: reserve x1..x31 over 31 cycles (busy_count=31), then flush, rsv_en rsv_wa=2 and lwen lwa=3 together.
  - Required: busy_count=0 next cycle; busy[2]=0; data[3]=lwd.
